// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Debounces two raw coin sensors (1-rupee, 2-rupee), classifies the coin and
//   hands a one-cycle coin code to the vending FSM. Coins that arrive while
//   the vending FSM is dispensing, or that trip both sensors at once, are
//   returned. A sensor that stays high too long after a coin is accepted
//   latches a sticky fault until reset.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   sense_1      raw 1-rupee sensor (asynchronous, bouncy, active-high)
//   sense_2      raw 2-rupee sensor (asynchronous, bouncy, active-high)
//   lockout      vending FSM dispensing; a coin accepted while high is rejected
//   coin_in      2'b01 one rupee, 2'b10 two rupees, one-cycle pulse, else 2'b00
//   coin_reject  one-cycle pulse: coin returned to customer
//   busy         high whenever the FSM is not idle
//   fault        sticky stuck-sensor flag
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_1,
    input  logic       sense_2,
    input  logic       lockout,
    output logic [1:0] coin_in,
    output logic       coin_reject,
    output logic       busy,
    output logic       fault
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE,
        FAULT
    } state_t;

    state_t          state, state_n;
    logic [1:0]      cand, cand_n;
    logic [DB_W-1:0] db_cnt, db_n;
    logic [DB_W-1:0] rel_cnt, rel_n;
    logic [ST_W-1:0] stuck_cnt, stuck_n;
    logic [1:0]      coin_in_n;
    logic            reject_n;

    logic s1_meta, s1_sync;
    logic s2_meta, s2_sync;
    logic [1:0] s_vec;

    // Two-flop synchronizers; nothing downstream looks at the raw sensors.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_meta <= 1'b0;
            s1_sync <= 1'b0;
            s2_meta <= 1'b0;
            s2_sync <= 1'b0;
        end else begin
            s1_meta <= sense_1;
            s1_sync <= s1_meta;
            s2_meta <= sense_2;
            s2_sync <= s2_meta;
        end
    end

    assign s_vec = {s2_sync, s1_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cand        <= '0;
            db_cnt      <= '0;
            rel_cnt     <= '0;
            stuck_cnt   <= '0;
            coin_in     <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            db_cnt      <= db_n;
            rel_cnt     <= rel_n;
            stuck_cnt   <= stuck_n;
            coin_in     <= coin_in_n;
            coin_reject <= reject_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        db_n      = db_cnt;
        rel_n     = rel_cnt;
        stuck_n   = stuck_cnt;
        coin_in_n = '0;
        reject_n  = 1'b0;

        case (state)
            IDLE: begin
                db_n    = '0;
                rel_n   = '0;
                stuck_n = '0;
                if (s_vec == 2'b01 || s_vec == 2'b10) begin
                    cand_n  = s_vec;
                    db_n    = DB_W'(1);
                    state_n = DEBOUNCE;
                end else if (s_vec == 2'b11) begin
                    // Both sensors at once cannot be a genuine coin.
                    reject_n = 1'b1;
                    state_n  = WAIT_RELEASE;
                end
            end

            DEBOUNCE: begin
                if (s_vec == cand) begin
                    if (db_cnt == DB_LAST) begin
                        // lockout matters only on this accept edge.
                        if (lockout) reject_n  = 1'b1;
                        else         coin_in_n = cand;
                        db_n    = '0;
                        state_n = WAIT_RELEASE;
                    end else if (db_cnt != '1) begin
                        db_n = db_cnt + 1'b1;
                    end
                end else begin
                    db_n    = '0;
                    state_n = IDLE;
                end
            end

            WAIT_RELEASE: begin
                if (s_vec == 2'b00) begin
                    stuck_n = '0;
                    if (rel_cnt == DB_LAST) begin
                        rel_n   = '0;
                        state_n = IDLE;
                    end else if (rel_cnt != '1) begin
                        rel_n = rel_cnt + 1'b1;
                    end
                end else begin
                    rel_n = '0;
                    if (stuck_cnt == ST_LAST) begin
                        state_n = FAULT;
                    end else if (stuck_cnt != '1) begin
                        stuck_n = stuck_cnt + 1'b1;
                    end
                end
            end

            FAULT: begin
                state_n = FAULT;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Decoded from the state register only, so no input reaches them combinationally.
    assign busy  = (state != IDLE);
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
//   Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, STUCK_CYCLES=16.
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
//   Inside each scenario loop, 'e' is the index of the edge just passed;
//   stimulus applied at the top of a scenario is in place before edge 0.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense_1;
    logic       sense_2;
    logic       lockout;
    logic [1:0] coin_in;
    logic       coin_reject;
    logic       busy;
    logic       fault;

    int tests = 0;
    int fails = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sense_1    (sense_1),
        .sense_2    (sense_2),
        .lockout    (lockout),
        .coin_in    (coin_in),
        .coin_reject(coin_reject),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".coin_in"}, {6'd0, coin_in}, 8'd0);
        check({tag, ".reject"},  {7'd0, coin_reject}, 8'd0);
        check({tag, ".busy"},    {7'd0, busy}, 8'd0);
        check({tag, ".fault"},   {7'd0, fault}, 8'd0);
    endtask

    int pat[13] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int n_coin;
    int n_rej;

    initial begin
        rst     = 1'b1;
        sense_1 = 1'b0;
        sense_2 = 1'b0;
        lockout = 1'b0;

        // Reset state
        step(2);
        check_idle_outputs("reset");
        rst = 1'b0;
        step(1);

        // Single 1-rupee coin, 10 cycles high
        sense_1 = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            step(1);
            if (e == 9) sense_1 = 1'b0;
            check($sformatf("one.coin_in@%0d", e), {6'd0, coin_in}, (e == 5) ? 8'd1 : 8'd0);
            check($sformatf("one.busy@%0d", e), {7'd0, busy}, (e >= 2 && e <= 14) ? 8'd1 : 8'd0);
            check($sformatf("one.reject@%0d", e), {7'd0, coin_reject}, 8'd0);
        end

        // Bouncy 2-rupee coin
        n_coin  = 0;
        n_rej   = 0;
        sense_2 = pat[0][0];
        for (int e = 0; e <= 22; e++) begin
            step(1);
            sense_2 = (e + 1 < 13) ? pat[e+1][0] : 1'b0;
            if (coin_in != 2'b00) n_coin++;
            if (coin_reject) n_rej++;
            check($sformatf("bounce.coin_in@%0d", e), {6'd0, coin_in}, (e == 10) ? 8'd2 : 8'd0);
            if (e >= 10 && e <= 17) check($sformatf("bounce.busy@%0d", e), {7'd0, busy}, 8'd1);
            if (e >= 18) check($sformatf("bounce.idle@%0d", e), {7'd0, busy}, 8'd0);
        end
        check("bounce.pulses", n_coin[7:0], 8'd1);
        check("bounce.rejects", n_rej[7:0], 8'd0);

        // Both sensors together
        sense_1 = 1'b1;
        sense_2 = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            step(1);
            if (e == 4) begin
                sense_1 = 1'b0;
                sense_2 = 1'b0;
            end
            check($sformatf("both.reject@%0d", e), {7'd0, coin_reject}, (e == 2) ? 8'd1 : 8'd0);
            check($sformatf("both.coin_in@%0d", e), {6'd0, coin_in}, 8'd0);
            check($sformatf("both.busy@%0d", e), {7'd0, busy}, (e >= 2 && e <= 9) ? 8'd1 : 8'd0);
        end

        // Lockout high at accept edge -> reject
        lockout = 1'b1;
        sense_1 = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            step(1);
            if (e == 5) lockout = 1'b0;
            if (e == 6) sense_1 = 1'b0;
            check($sformatf("lock.reject@%0d", e), {7'd0, coin_reject}, (e == 5) ? 8'd1 : 8'd0);
            check($sformatf("lock.coin_in@%0d", e), {6'd0, coin_in}, 8'd0);
            check($sformatf("lock.busy@%0d", e), {7'd0, busy}, (e >= 2 && e <= 11) ? 8'd1 : 8'd0);
        end

        // Next coin with lockout low; lockout rising after accept is ignored
        sense_1 = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            step(1);
            if (e == 6) begin
                lockout = 1'b1;
                sense_1 = 1'b0;
            end
            check($sformatf("relock.coin_in@%0d", e), {6'd0, coin_in}, (e == 5) ? 8'd1 : 8'd0);
            check($sformatf("relock.reject@%0d", e), {7'd0, coin_reject}, 8'd0);
        end
        check("relock.idle", {7'd0, busy}, 8'd0);
        lockout = 1'b0;

        // Stuck 2-rupee sensor -> accept once, then fault
        sense_2 = 1'b1;
        for (int e = 0; e <= 29; e++) begin
            step(1);
            if (e == 29) sense_2 = 1'b0;
            check($sformatf("stuck.coin_in@%0d", e), {6'd0, coin_in}, (e == 5) ? 8'd2 : 8'd0);
            check($sformatf("stuck.fault@%0d", e), {7'd0, fault}, (e >= 21) ? 8'd1 : 8'd0);
            check($sformatf("stuck.busy@%0d", e), {7'd0, busy}, (e >= 2) ? 8'd1 : 8'd0);
        end

        // Coins ignored while faulted
        sense_1 = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            step(1);
            if (e == 9) sense_1 = 1'b0;
            check($sformatf("faulted.coin_in@%0d", e), {6'd0, coin_in}, 8'd0);
            check($sformatf("faulted.reject@%0d", e), {7'd0, coin_reject}, 8'd0);
            check($sformatf("faulted.fault@%0d", e), {7'd0, fault}, 8'd1);
            check($sformatf("faulted.busy@%0d", e), {7'd0, busy}, 8'd1);
        end

        // Reset clears fault
        rst = 1'b1;
        step(1);
        check_idle_outputs("fault_rst");
        rst = 1'b0;
        step(2);

        // Reset during debounce (count 2), sensor still high afterwards
        sense_1 = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            step(1);
            if (e == 3) rst = 1'b1;
            if (e == 4) begin
                check_idle_outputs("mid_rst");
                rst = 1'b0;
            end
            check($sformatf("mid.coin_in@%0d", e), {6'd0, coin_in}, (e == 10) ? 8'd1 : 8'd0);
            check($sformatf("mid.reject@%0d", e), {7'd0, coin_reject}, 8'd0);
            check($sformatf("mid.busy@%0d", e), {7'd0, busy},
                  ((e >= 2 && e <= 3) || e >= 7) ? 8'd1 : 8'd0);
        end
        sense_1 = 1'b0;
        step(8);
        check_idle_outputs("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
